// File: rtl/burst_memory_slave_if.sv
// Bus bundle between a burst master (e.g. the DMA block) and burst_memory_slave.
// Carries the begin/end/data handshake; clock and reset stay plain module ports.
interface burst_memory_slave_if;
    logic        beginTransactionIn;
    logic        endTransactionIn;
    logic        readNotWriteIn;
    logic [7:0]  burstSizeIn;
    logic        dataValidIn;
    logic [31:0] addressDataIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;
    logic        busyOut;

    modport slave (
        input  beginTransactionIn,
        input  endTransactionIn,
        input  readNotWriteIn,
        input  burstSizeIn,
        input  dataValidIn,
        input  addressDataIn,
        output addressDataOut,
        output dataValidOut,
        output endTransactionOut,
        output busErrorOut,
        output busyOut
    );

    modport master (
        output beginTransactionIn,
        output endTransactionIn,
        output readNotWriteIn,
        output burstSizeIn,
        output dataValidIn,
        output addressDataIn,
        input  addressDataOut,
        input  dataValidOut,
        input  endTransactionOut,
        input  busErrorOut,
        input  busyOut
    );
endinterface

// File: rtl/burst_memory_slave.sv
// Burst read/write bus slave over an on-chip word RAM with a fixed address window.
// Define BURST_MEMORY_SLAVE_BYTE_SWAP_EN to byte-reverse data at the bus boundary.
module burst_memory_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int          ADDR_BITS    = 10,
    parameter int          READ_LATENCY = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    burst_memory_slave_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        RD_END,
        WR,
        ERR
    } state_t;

    localparam int         DEPTH     = 1 << ADDR_BITS;
    localparam int         SUM_W     = ((ADDR_BITS > 8) ? ADDR_BITS : 8) + 1;
    localparam logic [3:0] WAIT_LAST = 4'(READ_LATENCY - 2);

    state_t                 state_reg, state_next;
    logic [ADDR_BITS-1:0]   idx_reg, idx_next;
    logic [7:0]             burst_reg, burst_next;
    logic [8:0]             beat_reg, beat_next;
    logic [3:0]             wait_reg, wait_next;
    logic                   valid_reg, valid_next;
    logic [31:0]            data_reg, data_next;
    logic                   end_reg, end_next;
    logic                   err_reg, err_next;

    logic [31:0]            mem_array [0:DEPTH-1];
    logic [31:0]            ram_q;
    logic                   wr_en;
    logic [31:0]            wr_word;
    logic [31:0]            rd_word;

    logic                   hit;
    logic                   bad;
    logic [ADDR_BITS-1:0]   start_idx;
    logic [SUM_W-1:0]       end_sum;

    // Byte lanes: reversed when the swap option is built in, straight through otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
`ifdef BURST_MEMORY_SLAVE_BYTE_SWAP_EN
            assign wr_word[8*gi +: 8] = bus.addressDataIn[8*(3-gi) +: 8];
            assign rd_word[8*gi +: 8] = ram_q[8*(3-gi) +: 8];
`else
            assign wr_word[8*gi +: 8] = bus.addressDataIn[8*gi +: 8];
            assign rd_word[8*gi +: 8] = ram_q[8*gi +: 8];
`endif
        end
    endgenerate

    // Wide sum so a burst running past the top of the window is caught, not wrapped.
    assign hit       = (bus.addressDataIn[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2]);
    assign start_idx = bus.addressDataIn[ADDR_BITS+1:2];
    assign end_sum   = SUM_W'(start_idx) + SUM_W'(bus.burstSizeIn);
    assign bad       = (bus.addressDataIn[1:0] != 2'b00) || (end_sum > SUM_W'(DEPTH - 1));

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        burst_next = burst_reg;
        beat_next  = beat_reg;
        wait_next  = wait_reg;
        valid_next = 1'b0;
        data_next  = 32'd0;
        end_next   = 1'b0;
        err_next   = 1'b0;
        wr_en      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.beginTransactionIn && hit) begin
                    idx_next   = start_idx;
                    burst_next = bus.burstSizeIn;
                    beat_next  = 9'd0;
                    wait_next  = 4'd0;
                    if (bad)
                        state_next = ERR;
                    else if (bus.readNotWriteIn)
                        state_next = RD_WAIT;
                    else
                        state_next = WR;
                end
            end
            RD_WAIT: begin
                // The last wait cycle issues the first RAM read; idx then runs one word ahead.
                if (bus.endTransactionIn) begin
                    state_next = IDLE;
                end else if (wait_reg == WAIT_LAST) begin
                    state_next = RD_DATA;
                    idx_next   = idx_reg + 1'b1;
                end else begin
                    wait_next = wait_reg + 4'd1;
                end
            end
            RD_DATA: begin
                if (bus.endTransactionIn) begin
                    state_next = IDLE;
                end else begin
                    valid_next = 1'b1;
                    data_next  = rd_word;
                    idx_next   = idx_reg + 1'b1;
                    beat_next  = beat_reg + 9'd1;
                    if (beat_reg[7:0] == burst_reg)
                        state_next = RD_END;
                end
            end
            RD_END: begin
                end_next   = 1'b1;
                state_next = IDLE;
            end
            WR: begin
                if (bus.dataValidIn && (beat_reg <= {1'b0, burst_reg})) begin
                    wr_en     = 1'b1;
                    idx_next  = idx_reg + 1'b1;
                    beat_next = beat_reg + 9'd1;
                end
                if (bus.endTransactionIn)
                    state_next = IDLE;
            end
            ERR: begin
                end_next   = 1'b1;
                err_next   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            burst_reg <= 8'd0;
            beat_reg  <= 9'd0;
            wait_reg  <= 4'd0;
            valid_reg <= 1'b0;
            data_reg  <= 32'd0;
            end_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            burst_reg <= burst_next;
            beat_reg  <= beat_next;
            wait_reg  <= wait_next;
            valid_reg <= valid_next;
            data_reg  <= data_next;
            end_reg   <= end_next;
            err_reg   <= err_next;
        end
    end

    // Block RAM: no reset, registered read of the current index every cycle.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem_array[idx_reg] <= wr_word;
        ram_q <= mem_array[idx_reg];
    end

    assign bus.addressDataOut    = data_reg;
    assign bus.dataValidOut      = valid_reg;
    assign bus.endTransactionOut = end_reg;
    assign bus.busErrorOut       = err_reg;
    assign bus.busyOut           = (state_reg != IDLE);

endmodule

// File: tb/tb_burst_memory_slave.sv
// Scoreboard bench for burst_memory_slave: stimulus pushes expected beats with their cycle,
// a monitor pops and compares each time the slave drives valid/end/error.
module tb_burst_memory_slave;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        valid;
        logic        endt;
        logic        err;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t exp_q[$];
    logic [31:0] wr_buf [0:15];
    logic [31:0] rd_exp [0:15];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    burst_memory_slave_if bus_if();

    burst_memory_slave dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic expect_word(input int c, input logic [31:0] d);
        exp_q.push_back('{cyc: c, data: d, valid: 1'b1, endt: 1'b0, err: 1'b0});
    endtask

    task automatic expect_end(input int c, input logic e);
        exp_q.push_back('{cyc: c, data: 32'd0, valid: 1'b0, endt: 1'b1, err: e});
    endtask

    // Returns at the negedge of cycle t0 with begin already released.
    task automatic issue_begin(input logic [31:0] addr, input logic rnw, input logic [7:0] bsz,
                               output int t0);
        @(negedge clock);
        bus_if.beginTransactionIn = 1'b1;
        bus_if.addressDataIn      = addr;
        bus_if.readNotWriteIn     = rnw;
        bus_if.burstSizeIn        = bsz;
        t0 = cyc + 1;
        @(negedge clock);
        bus_if.beginTransactionIn = 1'b0;
        bus_if.addressDataIn      = 32'd0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] bsz, input int n);
        int t0;
        issue_begin(addr, 1'b0, bsz, t0);
        for (int i = 0; i < n; i++) begin
            bus_if.dataValidIn      = 1'b1;
            bus_if.addressDataIn    = wr_buf[i];
            bus_if.endTransactionIn = (i == n - 1);
            @(negedge clock);
        end
        bus_if.dataValidIn      = 1'b0;
        bus_if.endTransactionIn = 1'b0;
        bus_if.addressDataIn    = 32'd0;
        @(negedge clock);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] bsz);
        int t0;
        issue_begin(addr, 1'b1, bsz, t0);
        for (int k = 0; k <= int'(bsz); k++)
            expect_word(t0 + 2 + k, rd_exp[k]);
        expect_end(t0 + 3 + int'(bsz), 1'b0);
        while (cyc < t0 + int'(bsz) + 5) @(negedge clock);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (reset && (bus_if.dataValidOut || bus_if.endTransactionOut || bus_if.busErrorOut)) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_output: cyc %0d valid %b data %h end %b err %b, none required",
                         cyc, bus_if.dataValidOut, bus_if.addressDataOut,
                         bus_if.endTransactionOut, bus_if.busErrorOut);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || bus_if.addressDataOut !== e.data || bus_if.dataValidOut !== e.valid
                    || bus_if.endTransactionOut !== e.endt || bus_if.busErrorOut !== e.err) begin
                    mismatched++;
                    $display("FAIL beat: got cyc %0d valid %b data %h end %b err %b required cyc %0d valid %b data %h end %b err %b",
                             cyc, bus_if.dataValidOut, bus_if.addressDataOut, bus_if.endTransactionOut,
                             bus_if.busErrorOut, e.cyc, e.valid, e.data, e.endt, e.err);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        exp_t e;
        bus_if.beginTransactionIn = 1'b0;
        bus_if.endTransactionIn   = 1'b0;
        bus_if.readNotWriteIn     = 1'b0;
        bus_if.burstSizeIn        = 8'd0;
        bus_if.dataValidIn        = 1'b0;
        bus_if.addressDataIn      = 32'd0;

        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("reset_data",  bus_if.addressDataOut, 32'd0);
        check("reset_valid", {31'd0, bus_if.dataValidOut}, 32'd0);
        check("reset_end",   {31'd0, bus_if.endTransactionOut}, 32'd0);
        check("reset_err",   {31'd0, bus_if.busErrorOut}, 32'd0);
        check("reset_busy",  {31'd0, bus_if.busyOut}, 32'd0);

        // Write four words at 0x5000_0010, read them back.
        wr_buf[0] = 32'h1111_1111; wr_buf[1] = 32'h2222_2222;
        wr_buf[2] = 32'h3333_3333; wr_buf[3] = 32'h4444_4444;
        write_burst(32'h5000_0010, 8'd3, 4);
        rd_exp[0] = 32'h1111_1111; rd_exp[1] = 32'h2222_2222;
        rd_exp[2] = 32'h3333_3333; rd_exp[3] = 32'h4444_4444;
        read_burst(32'h5000_0010, 8'd3);

        // Last word of the window: single read is fine, two words is an error.
        wr_buf[0] = 32'hCAFE_F00D;
        write_burst(32'h5000_0FFC, 8'd0, 1);
        rd_exp[0] = 32'hCAFE_F00D;
        read_burst(32'h5000_0FFC, 8'd0);
        issue_begin(32'h5000_0FFC, 1'b1, 8'd1, t0);
        expect_end(t0 + 1, 1'b1);
        repeat (3) @(negedge clock);
        check("edge_err_idle", {31'd0, bus_if.busyOut}, 32'd0);

        // Misaligned address errors; out-of-window address is ignored.
        issue_begin(32'h5000_0002, 1'b1, 8'd0, t0);
        expect_end(t0 + 1, 1'b1);
        repeat (3) @(negedge clock);
        issue_begin(32'h6000_0000, 1'b1, 8'd0, t0);
        for (int i = 0; i < 3; i++) begin
            check("miss_busy", {31'd0, bus_if.busyOut}, 32'd0);
            @(negedge clock);
        end

        // Write burst of 2 sent 3 words: the third must not reach index 0x42.
        wr_buf[0] = 32'hDEAD_BEEF;
        write_burst(32'h5000_0108, 8'd0, 1);
        wr_buf[0] = 32'hAAAA_0001; wr_buf[1] = 32'hBBBB_0002; wr_buf[2] = 32'hCCCC_0003;
        write_burst(32'h5000_0100, 8'd1, 3);
        rd_exp[0] = 32'hAAAA_0001; rd_exp[1] = 32'hBBBB_0002; rd_exp[2] = 32'hDEAD_BEEF;
        read_burst(32'h5000_0100, 8'd2);

        // 16-word read aborted while the third word is on the bus.
        for (int i = 0; i < 16; i++) wr_buf[i] = 32'h0000_1000 + i;
        write_burst(32'h5000_0200, 8'd15, 16);
        issue_begin(32'h5000_0200, 1'b1, 8'd15, t0);
        for (int k = 0; k < 3; k++) expect_word(t0 + 2 + k, 32'h0000_1000 + k);
        while (cyc < t0 + 4) @(negedge clock);
        bus_if.endTransactionIn = 1'b1;
        @(negedge clock);
        bus_if.endTransactionIn = 1'b0;
        check("abort_busy", {31'd0, bus_if.busyOut}, 32'd0);
        repeat (20) @(negedge clock);

        // Reset asserted mid-burst of an 8-word read.
        issue_begin(32'h5000_0200, 1'b1, 8'd7, t0);
        for (int k = 0; k < 2; k++) expect_word(t0 + 2 + k, 32'h0000_1000 + k);
        while (cyc < t0 + 3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_mid_data",  bus_if.addressDataOut, 32'd0);
        check("rst_mid_valid", {31'd0, bus_if.dataValidOut}, 32'd0);
        check("rst_mid_end",   {31'd0, bus_if.endTransactionOut}, 32'd0);
        check("rst_mid_busy",  {31'd0, bus_if.busyOut}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        check("rst_mid_busy_after", {31'd0, bus_if.busyOut}, 32'd0);

`ifdef BURST_MEMORY_SLAVE_BYTE_SWAP_EN
        wr_buf[0] = 32'h0102_0304;
        write_burst(32'h5000_0300, 8'd0, 1);
        check("swap_ram", dut.mem_array[192], 32'h0403_0201);
        rd_exp[0] = 32'h0102_0304;
        read_burst(32'h5000_0300, 8'd0);
`endif

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL missing_beat: got nothing required cyc %0d valid %b data %h end %b err %b",
                     e.cyc, e.valid, e.data, e.endt, e.err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/burst_memory_slave.md
Name: burst_memory_slave

Overview:
- Memory-mapped bus slave backed by an on-chip word RAM.
- Sits directly upstream of the DMA custom-instruction block on the shared bus and serves its burst-read transactions.
- Also accepts burst writes, so the CPU and DMA can preload and verify contents.
- Decodes a fixed address window and answers with data, dataValid, endTransaction and busError in the bus protocol the DMA master consumes.

Parameters:
- BASE_ADDRESS, 32'h5000_0000, byte base of the decoded window; must be aligned to the window size.
- ADDR_BITS, 10, word-address width; window = 2^ADDR_BITS 32-bit words.
- READ_LATENCY, 2, cycles from the sampled beginTransaction to the first read word; legal 2..15.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- beginTransactionIn  in  1  master starts a transaction; address valid on addressDataIn.
- endTransactionIn  in  1  master ends a write burst or aborts a read.
- readNotWriteIn  in  1  1 = read, 0 = write; sampled with begin.
- burstSizeIn  in  8  burst length minus one; sampled with begin.
- dataValidIn  in  1  write word valid on addressDataIn.
- addressDataIn  in  32  address at begin, write data otherwise.
- addressDataOut  out  32  read data; 0 when dataValidOut = 0.
- dataValidOut  out  1  read word valid.
- endTransactionOut  out  1  one-cycle pulse closing a read or an error.
- busErrorOut  out  1  one-cycle pulse, coincident with endTransactionOut.
- busyOut  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; all outputs 0; counters 0.
  - RAM contents are undefined.
  - Reset asserted mid-burst aborts immediately; no endTransactionOut is issued.
- Decode:
  - Hit when addressDataIn[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2].
  - Word index = addressDataIn[ADDR_BITS+1:2].
  - A begin that misses is ignored: no output, stays IDLE.
- Error check on a hit:
  - Error if addressDataIn[1:0] != 0, or if word index + burstSizeIn > 2^ADDR_BITS - 1 (burst would leave the window).
  - Computed at ADDR_BITS+1 width so the sum cannot wrap.
  - Error path: go to ERR. Next cycle pulse busErrorOut = 1 and endTransactionOut = 1 for one cycle, then return to IDLE. No RAM access occurs.
- States:
  - IDLE: on a valid begin with readNotWriteIn = 1, go to RD_WAIT; with readNotWriteIn = 0, go to WR.
  - RD_WAIT: counts READ_LATENCY-1 cycles, covering the synchronous RAM read.
  - RD_DATA: dataValidOut = 1 for exactly burstSizeIn+1 consecutive cycles, word addresses ascending from the start index. The first word appears at cycle T0+READ_LATENCY, where T0 is the begin-sampling edge.
  - RD_END: endTransactionOut = 1 for one cycle immediately after the last word, then IDLE.
  - WR: each dataValidIn = 1 cycle writes addressDataIn to the current index, then increments the index.
    - Words beyond burstSizeIn+1 are dropped.
    - endTransactionIn returns to IDLE next cycle. A data word on the same cycle as endTransactionIn is still written.
  - ERR: as described under the error check.
- Abort: endTransactionIn = 1 during RD_WAIT or RD_DATA moves to IDLE next cycle. Outputs drop to 0 and no endTransactionOut is issued.
- beginTransactionIn while busyOut = 1 is ignored.
- burstSizeIn = 0 gives a single-word transfer; 255 gives 256 words, legal if the window bounds allow.

Optional Feature:
- Macro: BURST_MEMORY_SLAVE_BYTE_SWAP_EN.
- Defined: read data and write data are byte-reversed at the bus boundary ({b0,b1,b2,b3}), giving big-endian bus with little-endian storage. Write-then-read over the bus returns the original word; contents as stored in RAM are swapped.
- Undefined: data passes unmodified.
- Timing is identical in both cases.

Test Plan:
- Reset and single read: drive reset low mid-RD_DATA of an 8-word read -> all outputs 0 immediately, busyOut = 0, no endTransactionOut.
- Write then read: write 4 words 0x11111111..0x44444444 at 0x5000_0010 with burstSizeIn = 3, then read back with burstSizeIn = 3 -> dataValidOut high cycles T0+2..T0+5 with the same values; endTransactionOut at T0+6.
- Window edge: read at 0x5000_0FFC with burstSizeIn = 0 -> 1 word, no error. Same address with burstSizeIn = 1 -> busErrorOut and endTransactionOut at T0+1, dataValidOut never asserted.
- Misaligned and miss: begin at 0x5000_0002 -> error pulse. Begin at 0x6000_0000 -> no response, busyOut stays 0.
- Abort and overflow: endTransactionIn at the 3rd word of a 16-word read -> IDLE next cycle, no endTransactionOut. A write burst sized 2 words but sent 3 -> 3rd word not stored (RAM at index+2 unchanged).
- Byte swap (macro defined): write 0x01020304, read RAM directly -> 0x04030201; bus read-back -> 0x01020304.
